// File: rtl/enc_scan_ctrl.sv
// rtl/enc_scan_ctrl.sv - round-robin debounce/quadrature scan engine for NUM_CH rotary encoders
module enc_scan_ctrl #(
   parameter int NUM_CH      = 3,
   parameter int WIDTH       = 8,
   parameter int SLOT_CYCLES = 16,
   parameter int STEP        = 1,
   parameter int RESET_LEVEL = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic [NUM_CH-1:0]       enc_a,
   input  logic [NUM_CH-1:0]       enc_b,
   output logic [NUM_CH*WIDTH-1:0] level,
   output logic [NUM_CH-1:0]       level_upd,
   output logic [NUM_CH-1:0]       enc_err,
   output logic [1:0]              scan_ch
);

   localparam int             PW     = $clog2(SLOT_CYCLES);
   localparam logic [WIDTH:0] MAX_L  = {1'b0, {WIDTH{1'b1}}};
   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

   logic [NUM_CH-1:0] r_a_s1, r_a_s2, r_b_s1, r_b_s2;
   logic [PW-1:0]     r_presc;
   logic [1:0]        r_scan_ch;
   logic [1:0]        r_prev [NUM_CH];
   logic [1:0]        r_hist [NUM_CH];
   logic [NUM_CH-1:0] r_init;
   logic [WIDTH-1:0]  r_level [NUM_CH];
   logic [NUM_CH-1:0] r_upd, r_err;

   logic              w_tick;
   logic [1:0]        w_s, w_prev, w_hist;
   logic              w_init;
   logic [WIDTH-1:0]  w_lvl, w_new_lvl;
   logic [WIDTH:0]    w_sum;
   logic              w_do_init, w_do_hist, w_stable_new;
   logic              w_cw, w_ccw, w_illegal, w_inc, w_dec;

   // Next state in the clockwise order 00 -> 10 -> 11 -> 01 -> 00.
   function automatic logic [1:0] f_cw(input logic [1:0] x);
      case (x)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   assign w_tick = ena && (r_presc == PW'(SLOT_CYCLES-1));

   always_comb begin
      w_s    = 2'b00;
      w_prev = 2'b00;
      w_hist = 2'b00;
      w_init = 1'b0;
      w_lvl  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_scan_ch == 2'(c)) begin
            w_s    = {r_a_s2[c], r_b_s2[c]};
            w_prev = r_prev[c];
            w_hist = r_hist[c];
            w_init = r_init[c];
            w_lvl  = r_level[c];
         end
      end
   end

   always_comb begin
      w_do_init    = !w_init;
      w_do_hist    = w_init && (w_s != w_hist);
      w_stable_new = w_init && (w_s == w_hist) && (w_s != w_prev);
      w_cw         = (f_cw(w_prev) == w_s);
      w_ccw        = (f_cw(w_s) == w_prev);
      w_illegal    = w_stable_new && !w_cw && !w_ccw;
      w_inc        = w_stable_new && w_cw  && (w_s == 2'b00);
      w_dec        = w_stable_new && w_ccw && (w_s == 2'b00);
      w_sum        = {1'b0, w_lvl} + STEP_W;
      w_new_lvl    = w_lvl;
      if (w_inc) begin
         w_new_lvl = (w_sum > MAX_L) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
      end else if (w_dec) begin
         w_new_lvl = ({1'b0, w_lvl} < STEP_W) ? '0 : (w_lvl - STEP_W[WIDTH-1:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_s1    <= '0;
         r_a_s2    <= '0;
         r_b_s1    <= '0;
         r_b_s2    <= '0;
         r_presc   <= '0;
         r_scan_ch <= 2'b00;
         r_init    <= '0;
         r_upd     <= '0;
         r_err     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_prev[c]  <= 2'b00;
            r_hist[c]  <= 2'b00;
            r_level[c] <= WIDTH'(RESET_LEVEL);
         end
      end else begin
         // Synchronisers keep running while disabled so resume sees fresh inputs.
         r_a_s1 <= enc_a;
         r_a_s2 <= r_a_s1;
         r_b_s1 <= enc_b;
         r_b_s2 <= r_b_s1;
         r_upd  <= '0;
         r_err  <= '0;
         if (w_tick) begin
            r_presc   <= '0;
            r_scan_ch <= (r_scan_ch == 2'(NUM_CH-1)) ? 2'b00 : r_scan_ch + 2'b01;
            for (int c = 0; c < NUM_CH; c++) begin
               if (r_scan_ch == 2'(c)) begin
                  if (w_do_init) begin
                     r_prev[c] <= w_s;
                     r_hist[c] <= w_s;
                     r_init[c] <= 1'b1;
                  end
                  if (w_do_hist) begin
                     r_hist[c] <= w_s;
                  end
                  if (w_stable_new) begin
                     r_prev[c] <= w_s;
                  end
                  r_err[c] <= w_illegal;
                  if (w_new_lvl != w_lvl) begin
                     r_level[c] <= w_new_lvl;
                     r_upd[c]   <= 1'b1;
                  end
               end
            end
         end else if (ena) begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_level
      assign level[g*WIDTH +: WIDTH] = r_level[g];
   end

   assign level_upd = r_upd;
   assign enc_err   = r_err;
   assign scan_ch   = r_scan_ch;

endmodule
